cpu_program_sequencer: RTL and testbench

- Upstream feeder for the simple CPU `top` block (ports in_A, in_B, in_ctrl_bus, in_clk, out_Q).
- Holds a small loadable program memory and steps through it, driving one operand pair and control byte per instruction into `top`.
- Captures `top`'s 4-bit out_Q result after a fixed execution latency.
- Replaces manual stimulus with a self-running instruction stream that stops on a HALT word or at the end of memory.

---
 rtl/cpu_program_sequencer.sv | 170 +++++++++++++++++
 tb/tb_cpu_program_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_program_sequencer.sv
// ============================================================================
//  Module   : cpu_program_sequencer
//  Purpose  : Loadable program memory plus a small sequencer that issues one
//             operand pair and control byte per instruction to the CPU `top`
//             block and captures its out_Q result after a fixed latency.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_program_sequencer #(
  parameter int           DEPTH     = 16,
  parameter int           ADDR_W    = 4,
  parameter int           EXEC_LAT  = 1,
  parameter logic [7:0]   HALT_CTRL = 8'hFF
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_load_en,
  input  logic [ADDR_W-1:0] in_load_addr,
  input  logic [15:0]       in_load_data,
  input  logic              in_start,
  input  logic [3:0]        in_Q,
  output logic [3:0]        out_A,
  output logic [3:0]        out_B,
  output logic [7:0]        out_ctrl_bus,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_busy,
  output logic [3:0]        out_result,
  output logic              out_result_valid,
  output logic              out_done
);

  // Wait counter only needs to hold EXEC_LAT, which never exceeds 7.
  localparam int                CNT_W   = 3;
  localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        a_q, a_d;
  logic [3:0]        b_q, b_d;
  logic [7:0]        ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        result_q, result_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic [15:0]       mem_q [DEPTH];
  logic              mem_we;
  logic [15:0]       fetch_word;

  // Loads are honoured only while idle so a running program cannot be altered.
  assign mem_we     = (state_q == S_IDLE) && in_load_en;
  assign fetch_word = mem_q[pc_q];

  // Program memory: plain register array, deliberately untouched by reset.
  always_ff @(posedge in_clk) begin
    if (mem_we) begin
      mem_q[in_load_addr] <= in_load_data;
    end
  end

  // Next-state and registered-output computation for the sequencer.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A load in the same cycle takes priority over a start request.
        if (!in_load_en && in_start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (fetch_word[15:8] == HALT_CTRL) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          ctrl_d  = fetch_word[15:8];
          a_d     = fetch_word[7:4];
          b_d     = fetch_word[3:0];
          cnt_d   = CNT_W'(EXEC_LAT);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          result_d = in_Q;
          valid_d  = 1'b1;
          ctrl_d   = '0;
          a_d      = '0;
          b_d      = '0;
          // The last address ends the run; the counter never wraps.
          if (pc_q == PC_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_FETCH) || (state_d == S_EXEC);
  end

  // State and output registers with asynchronous abort on reset.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign out_A            = a_q;
  assign out_B            = b_q;
  assign out_ctrl_bus     = ctrl_q;
  assign out_pc           = pc_q;
  assign out_busy         = busy_q;
  assign out_result       = result_q;
  assign out_result_valid = valid_q;
  assign out_done         = done_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_program_sequencer.sv
// ============================================================================
//  Module   : tb_cpu_program_sequencer
//  Purpose  : Self-checking bench for cpu_program_sequencer with a timeline
//             model of the instruction stream and directed literal checks.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpu_program_sequencer;

  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  localparam int LAT = 1;
  localparam int P = LAT + 2;   // cycles per instruction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic        start = 1'b0;
  logic [3:0]  q = '0;
  logic        q_fix = 1'b0;
  logic [3:0]  q_val = '0;

  logic [3:0]  out_A, out_B, out_result, out_pc;
  logic [7:0]  out_ctrl_bus;
  logic        out_busy, out_result_valid, out_done;

  int vectors = 0;
  int miscompares = 0;
  int n_res = 0;
  int n_done = 0;
  int cyc = 0;
  int res_cyc[$];

  cpu_program_sequencer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .EXEC_LAT(LAT), .HALT_CTRL(8'hFF)
  ) dut (
    .in_clk(clk), .in_rst_n(rst_n), .in_load_en(load_en),
    .in_load_addr(load_addr), .in_load_data(load_data), .in_start(start),
    .in_Q(q), .out_A(out_A), .out_B(out_B), .out_ctrl_bus(out_ctrl_bus),
    .out_pc(out_pc), .out_busy(out_busy), .out_result(out_result),
    .out_result_valid(out_result_valid), .out_done(out_done)
  );

  always #5 clk = ~clk;

  // top's result input: random unless a test pins it
  always @(negedge clk) q = q_fix ? q_val : 4'($urandom);

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: run as a timeline ----------------
  logic [15:0] m_mem [DEPTH];
  int          m_phase;   // 0 idle, 1 running, 2 done cycle
  int          m_d;       // edges since the start edge
  logic [3:0]  e_a, e_b, e_res, e_pc;
  logic [7:0]  e_ctrl;
  logic        e_busy, e_val, e_done;

  always @(posedge clk or negedge rst_n) begin : model
    int j, r;
    logic [15:0] w;
    if (!rst_n) begin
      m_phase = 0; m_d = 0;
      e_a = 0; e_b = 0; e_res = 0; e_pc = 0; e_ctrl = 0;
      e_busy = 0; e_val = 0; e_done = 0;
    end else begin
      e_val = 0; e_done = 0;
      case (m_phase)
        0: begin
          if (load_en) m_mem[load_addr] = load_data;
          else if (start) begin
            m_phase = 1; m_d = 0; e_pc = 0; e_busy = 1;
          end
        end
        1: begin
          m_d++;
          j = (m_d - 1) / P;
          r = (m_d - 1) % P;
          if (r == 0) begin
            w = m_mem[j];
            if (w[15:8] == 8'hFF) begin
              m_phase = 2; e_busy = 0; e_done = 1;
            end else begin
              e_ctrl = w[15:8]; e_a = w[7:4]; e_b = w[3:0];
            end
          end else if (r == P - 1) begin
            e_res = q; e_val = 1; e_ctrl = 0; e_a = 0; e_b = 0;
            if (j == DEPTH - 1) begin
              m_phase = 2; e_busy = 0; e_done = 1;
            end else begin
              e_pc = 4'(j + 1);
            end
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // per-cycle comparison against the model, plus pulse bookkeeping
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst_n) begin
      check("A", 16'(out_A), 16'(e_a));
      check("B", 16'(out_B), 16'(e_b));
      check("ctrl", 16'(out_ctrl_bus), 16'(e_ctrl));
      check("pc", 16'(out_pc), 16'(e_pc));
      check("busy", 16'(out_busy), 16'(e_busy));
      check("result", 16'(out_result), 16'(e_res));
      check("valid", 16'(out_result_valid), 16'(e_val));
      check("done", 16'(out_done), 16'(e_done));
      if (out_result_valid) begin n_res++; res_cyc.push_back(cyc); end
      if (out_done) n_done++;
    end
  end

  // ---------------- stimulus helpers (entered just after a negedge) -----
  task automatic load(input logic [3:0] a, input logic [15:0] d);
    load_en = 1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 0;
  endtask

  task automatic start_pulse();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic clear_counts();
    n_res = 0; n_done = 0; res_cyc.delete();
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!out_done && k < budget) begin @(negedge clk); k++; end
    if (!out_done) begin
      miscompares++;
      $display("FAIL wait_done: timeout after %0d cycles, done=%b", k, out_done);
    end
  endtask

  logic [15:0] w0;
  logic [15:0] rw;
  int          snap;

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1;
    check("rst_ctrl", 16'(out_ctrl_bus), 16'h0);
    check("rst_pc", 16'(out_pc), 16'h0);
    check("rst_busy", 16'(out_busy), 16'h0);

    // T1: single instruction then HALT, fixed result
    load(4'd0, 16'h80D2); load(4'd1, 16'hFF00);
    q_fix = 1; q_val = 4'h5; clear_counts();
    start_pulse();
    @(negedge clk);
    check("t1_ctrl", 16'(out_ctrl_bus), 16'h80);
    check("t1_A", 16'(out_A), 16'hD);
    check("t1_B", 16'(out_B), 16'h2);
    wait_done(50);
    check("t1_result", 16'(out_result), 16'h5);
    check("t1_pulses", 16'(n_res), 16'd1);
    check("t1_dones", 16'(n_done), 16'd1);
    @(negedge clk);
    check("t1_busy_low", 16'(out_busy), 16'h0);
    q_fix = 0;

    // T2: three instructions then HALT
    load(4'd0, 16'h58E7); load(4'd1, 16'hB09A); load(4'd2, 16'hC6EC); load(4'd3, 16'hFF00);
    clear_counts();
    start_pulse();
    wait_done(50);
    check("t2_pulses", 16'(res_cyc.size()), 16'd3);
    if (res_cyc.size() == 3) begin
      check("t2_gap0", 16'(res_cyc[1] - res_cyc[0]), 16'd3);
      check("t2_gap1", 16'(res_cyc[2] - res_cyc[1]), 16'd3);
    end
    check("t2_pc_halt", 16'(out_pc), 16'd3);
    @(negedge clk);

    // T3: full memory, no HALT
    for (int i = 0; i < DEPTH; i++) load(4'(i), {8'h10, 8'($urandom)});
    clear_counts();
    start_pulse();
    wait_done(100);
    check("t3_pulses", 16'(n_res), 16'd16);
    check("t3_pc_end", 16'(out_pc), 16'd15);
    @(negedge clk);
    check("t3_pc_hold", 16'(out_pc), 16'd15);
    check("t3_dones", 16'(n_done), 16'd1);

    // T4: load during EXEC ignored, held start does not restart
    w0 = m_mem[0];
    clear_counts();
    start = 1;
    @(negedge clk); @(negedge clk);
    load_en = 1; load_addr = 4'd0; load_data = 16'hFFFF;
    @(negedge clk);
    load_en = 0;
    wait_done(100);
    start = 0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("t4_dones", 16'(n_done), 16'd1);
    check("t4_busy", 16'(out_busy), 16'h0);
    start_pulse();
    @(negedge clk);
    check("t4_rerun_ctrl", 16'(out_ctrl_bus), 16'(w0[15:8]));
    check("t4_rerun_A", 16'(out_A), 16'(w0[7:4]));
    wait_done(100);
    @(negedge clk);

    // T5: asynchronous reset mid-EXEC
    clear_counts();
    start_pulse();
    @(negedge clk); @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("t5_A", 16'(out_A), 16'h0);
    check("t5_B", 16'(out_B), 16'h0);
    check("t5_ctrl", 16'(out_ctrl_bus), 16'h0);
    check("t5_pc", 16'(out_pc), 16'h0);
    check("t5_busy", 16'(out_busy), 16'h0);
    check("t5_result", 16'(out_result), 16'h0);
    check("t5_valid", 16'(out_result_valid), 16'h0);
    check("t5_done", 16'(out_done), 16'h0);
    snap = n_done;
    @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    check("t5_no_done", 16'(n_done), 16'(snap));
    clear_counts();
    start_pulse();
    @(negedge clk);
    check("t5_rerun_ctrl", 16'(out_ctrl_bus), 16'(w0[15:8]));
    wait_done(100);
    check("t5_rerun_pulses", 16'(n_res), 16'd16);
    @(negedge clk);

    // T6: load and start together: load wins, stays idle
    load_en = 1; load_addr = 4'd0; load_data = 16'h2A5B; start = 1;
    @(negedge clk);
    load_en = 0; start = 0;
    check("t6_idle0", 16'(out_busy), 16'h0);
    @(negedge clk);
    check("t6_idle1", 16'(out_busy), 16'h0);
    load(4'd1, 16'hFF00);
    start_pulse();
    @(negedge clk);
    check("t6_ctrl", 16'(out_ctrl_bus), 16'h2A);
    check("t6_A", 16'(out_A), 16'h5);
    check("t6_B", 16'(out_B), 16'hB);
    wait_done(50);
    @(negedge clk);

    // Randomized programs with random HALT placement
    for (int run = 0; run < 8; run++) begin
      for (int i = 0; i < DEPTH; i++) begin
        rw = 16'($urandom);
        if ($urandom_range(0, 7) == 0) rw[15:8] = 8'hFF;
        load(4'(i), rw);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_pulse();
      wait_done(120);
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
